pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter: LEN_W, default 8, width of the length input and internal counter.
REQ-002 Parameter: MIN_GAP, default 1, minimum number of low cycles on signal between two stretched pulses; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: pulse  input  1  single-cycle trigger request; a multi-cycle high counts as a trigger on every high cycle.
REQ-006 Port: len  input  LEN_W  stretched length in cycles, sampled only in the cycle a trigger is accepted.
REQ-007 Port: signal  output  1  registered stretched level output.
REQ-008 Port: busy  output  1  high whenever the state is not IDLE.
REQ-009 Port: done  output  1  one-cycle pulse in the first cycle signal is low after a stretch.
REQ-010 Port: dropped  output  1  one-cycle pulse when a trigger is seen and not accepted.

Function
REQ-011 FSM states: IDLE, HIGH, GAP.
REQ-012 IDLE, pulse=1, len!=0: load counter with len, go to HIGH; signal goes high on that same edge, so it is visible in the next cycle (latency 1).
REQ-013 IDLE, pulse=1, len=0: trigger ignored, no state change, dropped=0.
REQ-014 HIGH: signal=1; counter decrements each cycle; when the counter reaches 1, the next edge goes to GAP with signal=0 and done=1. signal is high for exactly len cycles.
REQ-015 GAP: signal=0 for exactly MIN_GAP cycles, then IDLE. A trigger in GAP is not accepted and asserts dropped in the next cycle.
REQ-016 A trigger in HIGH is handled per REQ-022/REQ-023.
REQ-017 A trigger is accepted in the final GAP cycle only through IDLE. No trigger is accepted earlier than MIN_GAP low cycles after a stretch.
REQ-018 len=2**LEN_W-1 yields a full-scale stretch. Counter arithmetic is unsigned, with no wrap-around below 1.
REQ-019 done and dropped are never high in the same cycle as each other's cause. Both are registered.

Reset
REQ-020 rst=1 at an edge forces state IDLE, counter 0, signal=0, busy=0, done=0, dropped=0 on that edge. This overrides pulse in the same cycle.
REQ-021 Reset during HIGH or GAP aborts immediately; no done pulse is generated for the aborted stretch.

Configuration
REQ-022 Macro PULSE_STRETCHER_RETRIGGER_EN defined: a trigger in HIGH with len!=0 reloads the counter with len, and signal stays high without a gap. Total high time = cycles already elapsed + new len. dropped=0; done fires only once, at the final fall.
REQ-023 Macro undefined: a trigger in HIGH is ignored and asserts dropped in the next cycle; the counter is unaffected.

Structure
REQ-024 Shared package pulse_pkg holds the state enum (IDLE/HIGH/GAP) and the default constants for LEN_W and MIN_GAP.
REQ-025 One sub-module is natural: stretch_counter, a loadable down-counter with load, dec and at_one outputs, used for both the HIGH and GAP phases.
REQ-026 The FSM, output registers and macro-dependent logic stay in pulse_stretcher.

Verification
REQ-027 Basic stretch: rst 2 cycles, then pulse at cycle 10 with len=5 -> signal high cycles 11-15; done=1 at cycle 16; busy high cycles 11-16 (MIN_GAP=1).
REQ-028 Zero length: pulse with len=0 in IDLE -> signal, busy, done and dropped all stay 0.
REQ-029 Gap blocking (MIN_GAP=3): len=2 at cycle 10 -> signal high cycles 11-12, low 13-15. A pulse at cycle 14 -> dropped=1 at cycle 15 and no stretch. A pulse at cycle 16 -> accepted.
REQ-030 Retrigger (macro defined): len=4 at cycle 10, pulse len=4 at cycle 12 -> signal high cycles 11-16, single done at cycle 17.
REQ-031 Retrigger disabled: same stimulus as REQ-030 -> signal high cycles 11-14, dropped=1 at cycle 13, done at cycle 15.
REQ-032 Mid-stretch reset: len=8 at cycle 10, rst at cycle 13 -> signal=0 and busy=0 from cycle 14; no done pulse at any time.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and default constants for the pulse stretcher.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned LEN_W_DEFAULT   = 8;
  localparam int unsigned MIN_GAP_DEFAULT = 1;

endpackage

// File: rtl/stretch_counter.sv
// Loadable down-counter shared by the HIGH and GAP phases; saturates at 1.
module stretch_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         at_one
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q > W'(1))) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_one = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a trigger into a len-cycle high level followed by a MIN_GAP low gap.
// Define PULSE_STRETCHER_RETRIGGER_EN to let a trigger during HIGH reload the length.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEFAULT,
  parameter int unsigned MIN_GAP = MIN_GAP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic [LEN_W-1:0] len,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic             dropped
);

  // Counter is wide enough for both the length and the full MIN_GAP range.
  localparam int unsigned      CNT_W    = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP);

  state_e           state_q, state_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_at_one;
  logic             retrig;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign retrig = pulse && (len != '0);
`else
  assign retrig = 1'b0;
`endif

  stretch_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .at_one   (cnt_at_one)
  );

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    dropped_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = CNT_W'(len);
    case (state_q)
      IDLE: begin
        if (pulse && (len != '0)) begin
          cnt_load = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (retrig) begin
          cnt_load = 1'b1;
        end else begin
          dropped_d = pulse;
          if (cnt_at_one) begin
            state_d      = GAP;
            done_d       = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      GAP: begin
        dropped_d = pulse;
        if (cnt_at_one) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Level outputs follow the next state so they change on the same edge.
    signal_d = (state_d == HIGH);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      signal_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      signal_q  <= signal_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign signal  = signal_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random stimulus against a
// timestamp model, on two instances (MIN_GAP=1 and MIN_GAP=3).
module tb_pulse_stretcher;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       pulse;
  logic [7:0] len;
  logic [1:0] sig_o, busy_o, done_o, drop_o;

  int n_checks;
  int n_errors;
  int t;

  // Model: last cycle signal is high and last busy cycle, per instance.
  int   hi_end  [2];
  int   gap_end [2];
  int   mg      [2];
  logic exp_drop[2];

  pulse_stretcher #(.LEN_W(8), .MIN_GAP(1)) dut1 (
    .clk(clk), .rst(rst), .pulse(pulse), .len(len),
    .signal(sig_o[0]), .busy(busy_o[0]), .done(done_o[0]), .dropped(drop_o[0])
  );

  pulse_stretcher #(.LEN_W(8), .MIN_GAP(3)) dut3 (
    .clk(clk), .rst(rst), .pulse(pulse), .len(len),
    .signal(sig_o[1]), .busy(busy_o[1]), .done(done_o[1]), .dropped(drop_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs r/p/l are held during cycle t and take effect at its closing edge.
  task automatic model_update(input logic r, input logic p, input logic [7:0] l);
    for (int k = 0; k < 2; k++) begin
      exp_drop[k] = 1'b0;
      if (r) begin
        hi_end[k]  = -100;
        gap_end[k] = -100;
      end else if (p) begin
        if (t > gap_end[k]) begin
          if (l != 8'd0) begin
            hi_end[k]  = t + int'(l);
            gap_end[k] = hi_end[k] + mg[k];
          end
        end else if (t <= hi_end[k] && RETRIG && l != 8'd0) begin
          hi_end[k]  = t + int'(l);
          gap_end[k] = hi_end[k] + mg[k];
        end else begin
          exp_drop[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic p, input logic [7:0] l);
    rst   = r;
    pulse = p;
    len   = l;
    @(posedge clk);
    model_update(r, p, l);
    t++;
    #1;
    chk("d1.signal",  32'(sig_o[0]),  32'(t <= hi_end[0]));
    chk("d1.busy",    32'(busy_o[0]), 32'(t <= gap_end[0]));
    chk("d1.done",    32'(done_o[0]), 32'(t == hi_end[0] + 1));
    chk("d1.dropped", 32'(drop_o[0]), 32'(exp_drop[0]));
    chk("d3.signal",  32'(sig_o[1]),  32'(t <= hi_end[1]));
    chk("d3.busy",    32'(busy_o[1]), 32'(t <= gap_end[1]));
    chk("d3.done",    32'(done_o[1]), 32'(t == hi_end[1] + 1));
    chk("d3.dropped", 32'(drop_o[1]), 32'(exp_drop[1]));
  endtask

  initial begin
    int         hi_cnt;
    int         done_at;
    logic       rr, rp;
    logic [7:0] rl;

    n_checks = 0;
    n_errors = 0;
    t        = 0;
    mg[0] = 1;
    mg[1] = 3;
    for (int k = 0; k < 2; k++) begin
      hi_end[k]   = -100;
      gap_end[k]  = -100;
      exp_drop[k] = 1'b0;
    end
    rst   = 1'b1;
    pulse = 1'b0;
    len   = 8'd0;
    #1;

    // Reset state, with a pulse asserted that reset must override.
    step(1'b1, 1'b1, 8'd5);
    chk("reset.signal", 32'(sig_o[0]), 32'd0);
    chk("reset.busy",   32'(busy_o[0]), 32'd0);

    // Basic stretch, len=5, MIN_GAP=1.
    for (int c = 0; c < 20; c++) begin
      step(c < 2, c == 10, 8'd5);
      chk("basic.signal", 32'(sig_o[0]),  32'(c + 1 >= 11 && c + 1 <= 15));
      chk("basic.busy",   32'(busy_o[0]), 32'(c + 1 >= 11 && c + 1 <= 16));
      chk("basic.done",   32'(done_o[0]), 32'(c + 1 == 16));
    end

    // Zero length is ignored silently.
    for (int c = 0; c < 16; c++) begin
      step(c < 2, c == 10, 8'd0);
      chk("zero.signal",  32'(sig_o[0]),  32'd0);
      chk("zero.busy",    32'(busy_o[0]), 32'd0);
      chk("zero.done",    32'(done_o[0]), 32'd0);
      chk("zero.dropped", 32'(drop_o[0]), 32'd0);
    end

    // Gap blocking on the MIN_GAP=3 instance.
    for (int c = 0; c < 24; c++) begin
      step(c < 2, c == 10 || c == 14 || c == 16, 8'd2);
      chk("gap.signal",  32'(sig_o[1]),
          32'((c + 1 >= 11 && c + 1 <= 12) || (c + 1 >= 17 && c + 1 <= 18)));
      chk("gap.dropped", 32'(drop_o[1]), 32'(c + 1 == 15));
      chk("gap.done",    32'(done_o[1]), 32'(c + 1 == 13 || c + 1 == 19));
    end

    // Trigger during HIGH: retrigger or drop depending on build.
    for (int c = 0; c < 22; c++) begin
      step(c < 2, c == 10 || c == 12, 8'd4);
      if (RETRIG) begin
        chk("retrig.signal",  32'(sig_o[0]), 32'(c + 1 >= 11 && c + 1 <= 16));
        chk("retrig.done",    32'(done_o[0]), 32'(c + 1 == 17));
        chk("retrig.dropped", 32'(drop_o[0]), 32'd0);
      end else begin
        chk("noretrig.signal",  32'(sig_o[0]), 32'(c + 1 >= 11 && c + 1 <= 14));
        chk("noretrig.done",    32'(done_o[0]), 32'(c + 1 == 15));
        chk("noretrig.dropped", 32'(drop_o[0]), 32'(c + 1 == 13));
      end
    end

    // Reset mid-stretch aborts without a done pulse.
    for (int c = 0; c < 26; c++) begin
      step(c < 2 || c == 13, c == 10, 8'd8);
      chk("abort.signal", 32'(sig_o[0]),  32'(c + 1 >= 11 && c + 1 <= 13));
      chk("abort.busy",   32'(busy_o[0]), 32'(c + 1 >= 11 && c + 1 <= 13));
      chk("abort.done",   32'(done_o[0] | done_o[1]), 32'd0);
    end

    // Full-scale length.
    hi_cnt  = 0;
    done_at = -1;
    for (int c = 0; c < 280; c++) begin
      step(c < 2, c == 10, 8'hFF);
      if (sig_o[0] === 1'b1) hi_cnt++;
      if (done_o[0] === 1'b1) done_at = c + 1;
    end
    chk("full.high_cycles", 32'(hi_cnt), 32'd255);
    chk("full.done_cycle",  32'(done_at), 32'd266);

    // Random stimulus; len=0 only offered while both instances are idle.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rp = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 19))
        0:       rl = 8'hFF;
        1, 2:    rl = 8'd1;
        default: rl = 8'($urandom_range(1, 12));
      endcase
      if (t > gap_end[0] && t > gap_end[1] && $urandom_range(0, 3) == 0) rl = 8'd0;
      step(rr, rp, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
